// File: rtl/ksa_seq_pkg.sv
// Shared definitions for the digit-serial KSA add sequencer: digit width and FSM state encoding.
package ksa_seq_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    function automatic int digitCount(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/ksa_seq_ctrl_ksa.sv
// 4-bit Kogge-Stone adder: two parallel-prefix levels over generate/propagate, carry-in folded in last.
module ksa (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [4:0] o_sum
);

    logic [3:0] w_g0, w_p0, w_g1, w_p1, w_g2, w_p2, w_c;

    // After level 2, (w_g2[i], w_p2[i]) spans bits i..0, so every carry depends only on it and i_cin.
    always_comb begin
        w_g0 = i_a & i_b;
        w_p0 = i_a ^ i_b;
        w_g1 = w_g0;
        w_p1 = w_p0;
        for (int i = 1; i < 4; i++) begin
            w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
            w_p1[i] = w_p0[i] & w_p0[i-1];
        end
        w_g2 = w_g1;
        w_p2 = w_p1;
        for (int i = 2; i < 4; i++) begin
            w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
            w_p2[i] = w_p1[i] & w_p1[i-2];
        end
        w_c[0] = i_cin;
        for (int i = 1; i < 4; i++) begin
            w_c[i] = w_g2[i-1] | (w_p2[i-1] & i_cin);
        end
        o_sum[3:0] = w_p0 ^ w_c;
        o_sum[4]   = w_g2[3] | (w_p2[3] & i_cin);
    end

endmodule

// File: rtl/ksa_seq_ctrl.sv
// Multi-precision adder that streams WIDTH-bit operands through one 4-bit KSA, LSB digit first.
// Optional subtract mode (in_sub port) is built when KSA_SEQ_SUB_EN is defined.
module ksa_seq_ctrl
    import ksa_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef KSA_SEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             busy
);

    localparam int NDIG  = digitCount(WIDTH);
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    generate
        if ((WIDTH % DIGIT_W) != 0 || WIDTH < DIGIT_W) begin : g_width_check
            $error("ksa_seq_ctrl: WIDTH must be a non-zero multiple of 4");
        end
    endgenerate

    seq_state_t         r_state, w_next_state;
    logic [WIDTH-1:0]   r_a, r_b, r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               w_accept, w_b_invert, w_cin_load;
    logic [DIGIT_W-1:0] w_a_dig, w_b_dig;
    logic [DIGIT_W:0]   w_dig_sum;

`ifdef KSA_SEQ_SUB_EN
    logic r_sub;

    // Subtraction is A + ~B + 1, so the carry chain is seeded with 1 instead of the caller's carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sub <= 1'b0;
        else if (w_accept)
            r_sub <= in_sub;
    end

    assign w_b_invert = r_sub;
    assign w_cin_load = in_sub ? 1'b1 : in_cin;
`else
    assign w_b_invert = 1'b0;
    assign w_cin_load = in_cin;
`endif

    assign w_accept = in_valid & in_ready;
    assign w_a_dig  = r_a[DIGIT_W-1:0];
    assign w_b_dig  = r_b[DIGIT_W-1:0] ^ {DIGIT_W{w_b_invert}};

    ksa u_ksa (
        .i_a   (w_a_dig),
        .i_b   (w_b_dig),
        .i_cin (r_carry),
        .o_sum (w_dig_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next_state = ST_RUN;
            ST_RUN:  if (r_cnt == LAST_DIG) w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE) && !rst;
        out_valid = (r_state == ST_DONE);
        busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
        out_sum   = out_valid ? {r_carry, r_sum} : '0;
    end

    // Each RUN cycle consumes the low digit of A/B and pushes its sum digit in at the top of r_sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_cnt   <= '0;
            r_carry <= w_cin_load;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> DIGIT_W;
            r_b     <= r_b >> DIGIT_W;
            r_sum   <= (r_sum >> DIGIT_W) |
                       (WIDTH'(w_dig_sum[DIGIT_W-1:0]) << (WIDTH - DIGIT_W));
            r_carry <= w_dig_sum[DIGIT_W];
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ksa_seq_ctrl.sv
// Self-checking bench for ksa_seq_ctrl: directed cases, backpressure, mid-run reset, then random ops.
// Subtract cases are included when KSA_SEQ_SUB_EN is defined.
module tb_ksa_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int NDIG  = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             inValid, inReady, inCin, inSub;
    logic [WIDTH-1:0] inA, inB;
    logic             outValid, outReady, busy;
    logic [WIDTH:0]   outSum;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    ksa_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_a      (inA),
        .in_b      (inB),
        .in_cin    (inCin),
`ifdef KSA_SEQ_SUB_EN
        .in_sub    (inSub),
`endif
        .out_valid (outValid),
        .out_ready (outReady),
        .out_sum   (outSum),
        .busy      (busy)
    );

    // Plain wide arithmetic, truncated to WIDTH+1 bits.
    function automatic logic [WIDTH:0] refSum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic cin, input logic sub);
        longint unsigned total;
        logic [WIDTH-1:0] nb;
        nb    = ~b;
        total = a;
        if (sub) total = total + nb + 1;
        else     total = total + b + cin;
        return total[WIDTH:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
        @(negedge clk);
        inA     = a;
        inB     = b;
        inCin   = cin;
        inSub   = sub;
        inValid = 1'b1;
        checkOutput("ready_before_accept", inReady, 1);
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("busy_after_accept", busy, 1);
    endtask

    task automatic waitResult(input string tag, input logic [WIDTH:0] expected,
                              input int holdCycles, input bit pokeValid);
        int latency = 0;
        while (outValid !== 1'b1 && latency < 4 * NDIG + 8) begin
            @(negedge clk);
            latency++;
        end
        checkOutput({tag, "_latency"}, latency, NDIG);
        checkOutput({tag, "_valid"}, outValid, 1);
        checkOutput({tag, "_sum"}, outSum, expected);
        for (int i = 0; i < holdCycles; i++) begin
            if (pokeValid) begin
                inA     = WIDTH'($urandom);
                inB     = WIDTH'($urandom);
                inValid = 1'b1;
            end
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, outValid, 1);
            checkOutput({tag, "_hold_sum"}, outSum, expected);
            checkOutput({tag, "_hold_ready"}, inReady, 0);
            checkOutput({tag, "_hold_busy"}, busy, 1);
        end
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady = 1'b0;
        inValid  = 1'b0;
        checkOutput({tag, "_valid_cleared"}, outValid, 0);
        checkOutput({tag, "_idle_busy"}, busy, 0);
        checkOutput({tag, "_idle_ready"}, inReady, 1);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs;
        int               hold;

        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        inA      = '0;
        inB      = '0;
        inCin    = 1'b0;
        inSub    = 1'b0;
        #12;
        checkOutput("reset_in_ready", inReady, 0);
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_out_sum", outSum, 0);
        checkOutput("reset_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_ready", inReady, 1);

        $display("[TB] directed adds");
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
        waitResult("zero", 17'h00000, 0, 1'b0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        waitResult("ripple", 17'h10000, 1, 1'b0);
        applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0);
        waitResult("cin", 17'h05556, 0, 1'b0);

        $display("[TB] backpressure with concurrent in_valid");
        applyStimulus(16'hABCD, 16'h1111, 1'b0, 1'b0);
        waitResult("backpressure", refSum(16'hABCD, 16'h1111, 1'b0, 1'b0), 5, 1'b1);

        $display("[TB] reset mid-operation");
        applyStimulus(16'h00FF, 16'h0F0F, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_out_valid", outValid, 0);
        checkOutput("midrst_out_sum", outSum, 0);
        checkOutput("midrst_in_ready", inReady, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_release_ready", inReady, 1);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
        waitResult("after_reset", 17'h00002, 0, 1'b0);

`ifdef KSA_SEQ_SUB_EN
        $display("[TB] subtract mode");
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
        waitResult("sub_borrow", 17'h0FFFE, 0, 1'b0);
        applyStimulus(16'h0007, 16'h0005, 1'b0, 1'b1);
        waitResult("sub_noborrow", 17'h10002, 1, 1'b0);
`endif

        $display("[TB] random operations");
        for (int n = 0; n < 16; n++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rc   = 1'($urandom_range(0, 1));
`ifdef KSA_SEQ_SUB_EN
            rs   = 1'($urandom_range(0, 1));
`else
            rs   = 1'b0;
`endif
            hold = $urandom_range(0, 3);
            applyStimulus(ra, rb, rc, rs);
            waitResult("random", refSum(ra, rb, rc, rs), hold, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
